// File: rtl/branch_hazard_ctrl_if.sv
// Front-end control bundle between the fetch/decode pipeline and branch_hazard_ctrl.
//   master : pipeline side. It drives the branch/flag/stall inputs and receives
//            the stall/flush/redirect controls and the performance counters.
//   slave  : controller side.
//   branchD, branchTypeD[2:0], takenD, flagWE[1:0], stall_in  -> controller
//   stallF, stallD, flushD, flushE, pcRedirect                <- controller
//   branch_cnt, taken_cnt, hazard_cnt [CNT_W-1:0]             <- controller
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             branchD;
    logic [2:0]       branchTypeD;
    logic             takenD;
    logic [1:0]       flagWE;
    logic             stall_in;
    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             flushE;
    logic             pcRedirect;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] hazard_cnt;

    modport master (
        output branchD, branchTypeD, takenD, flagWE, stall_in,
        input  stallF, stallD, flushD, flushE, pcRedirect,
        input  branch_cnt, taken_cnt, hazard_cnt
    );

    modport slave (
        input  branchD, branchTypeD, takenD, flagWE, stall_in,
        output stallF, stallD, flushD, flushE, pcRedirect,
        output branch_cnt, taken_cnt, hazard_cnt
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller for the fetch/decode front end.
// Stalls a Decode branch while an Execute instruction is still writing the
// flags it reads, then issues the PC redirect and wrong-path flushes for taken
// branches, and keeps saturating branch performance counters.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : branch_hazard_ctrl_if.slave (branch/flag/stall inputs,
//            stall/flush/redirect outputs, performance counters)
//
// state     | meaning
// RUN       | normal issue; branches in Decode are resolved here
// FLAG_WAIT | waiting for the flag register to receive an in-flight write
// REDIRECT  | flushing wrong-path fetches after a taken branch
module branch_hazard_ctrl #(
    parameter int FLAG_LAT        = 1,
    parameter int REDIRECT_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input logic                 clk,
    input logic                 reset,
    branch_hazard_ctrl_if.slave bus
);
    localparam int MAX_WAIT = (FLAG_LAT > REDIRECT_CYCLES) ? FLAG_LAT : REDIRECT_CYCLES;
    localparam int WCNT_W   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLAG_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]    hazard_cnt_q, hazard_cnt_d;

    logic [1:0]          need;
    logic                dep;
    logic                stall_f, stall_d, flush_d, flush_e, pc_redirect;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // need[1] covers flags[3:2], need[0] covers flags[1:0], matching FlagW.
    always_comb begin
        need = 2'b00;
        case (bus.branchTypeD)
            3'b001:                 need = 2'b10;
            3'b010:                 need = 2'b01;
            3'b011, 3'b100, 3'b101: need = 2'b11;
            default:                need = 2'b00;
        endcase
    end

    assign dep = bus.branchD & (|(need & bus.flagWE));

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        pc_redirect  = 1'b0;

        if (bus.stall_in) begin
            // External stall freezes everything, including a branch resolving now.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (dep) begin
                        // takenD is based on stale flags here, so it is dropped.
                        stall_f      = 1'b1;
                        stall_d      = 1'b1;
                        flush_e      = 1'b1;
                        hazard_cnt_d = sat_inc(hazard_cnt_q);
                        if (FLAG_LAT > 1) begin
                            state_d = FLAG_WAIT;
                            wcnt_d  = WCNT_W'(FLAG_LAT - 2);
                        end
                    end else if (bus.branchD) begin
                        branch_cnt_d = sat_inc(branch_cnt_q);
                        if (bus.takenD) begin
                            pc_redirect = 1'b1;
                            flush_d     = 1'b1;
                            taken_cnt_d = sat_inc(taken_cnt_q);
                            if (REDIRECT_CYCLES > 1) begin
                                state_d = REDIRECT;
                                wcnt_d  = WCNT_W'(REDIRECT_CYCLES - 2);
                            end
                        end
                    end
                end
                FLAG_WAIT: begin
                    stall_f      = 1'b1;
                    stall_d      = 1'b1;
                    flush_e      = 1'b1;
                    hazard_cnt_d = sat_inc(hazard_cnt_q);
                    if (wcnt_q == '0) state_d = RUN;
                    else              wcnt_d  = wcnt_q - WCNT_W'(1);
                end
                REDIRECT: begin
                    // Decode holds wrong-path instructions; branchD/takenD ignored.
                    flush_d = 1'b1;
                    if (wcnt_q == '0) state_d = RUN;
                    else              wcnt_d  = wcnt_q - WCNT_W'(1);
                end
                default: begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            wcnt_q       <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign bus.stallF     = stall_f;
    assign bus.stallD     = stall_d;
    assign bus.flushD     = flush_d;
    assign bus.flushE     = flush_e;
    assign bus.pcRedirect = pc_redirect;
    assign bus.branch_cnt = branch_cnt_q;
    assign bus.taken_cnt  = taken_cnt_q;
    assign bus.hazard_cnt = hazard_cnt_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl: three instances with different parameter
// sets share one stimulus stream; a reference model predicts each instance's
// outputs into a queue and a monitor compares them on the falling edge.
module tb_branch_hazard_ctrl;
    localparam int N = 3;
    localparam int FL0 = 1, RC0 = 1, W0 = 16;
    localparam int FL1 = 3, RC1 = 3, W1 = 16;
    localparam int FL2 = 2, RC2 = 2, W2 = 4;

    int fl_p[N] = '{FL0, FL1, FL2};
    int rc_p[N] = '{RC0, RC1, RC2};
    int w_p[N]  = '{W0, W1, W2};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.CNT_W(W0)) if0 ();
    branch_hazard_ctrl_if #(.CNT_W(W1)) if1 ();
    branch_hazard_ctrl_if #(.CNT_W(W2)) if2 ();

    branch_hazard_ctrl #(.FLAG_LAT(FL0), .REDIRECT_CYCLES(RC0), .CNT_W(W0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    branch_hazard_ctrl #(.FLAG_LAT(FL1), .REDIRECT_CYCLES(RC1), .CNT_W(W1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    branch_hazard_ctrl #(.FLAG_LAT(FL2), .REDIRECT_CYCLES(RC2), .CNT_W(W2))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        bit rst; bit br; int typ; bit tk; int fwe; bit st;
    } stim_t;

    // chk: 0 = nothing known, 1 = counters only, 2 = everything
    typedef struct {
        bit sF; bit sD; bit fD; bit fE; bit pr;
        int bc; int tc; int hc; int chk;
    } obs_t;

    // mode: 0 free, 1 waiting on flags, 2 flushing after redirect
    typedef struct {
        int mode; int left; int bc; int tc; int hc; bit known;
    } mst_t;

    mst_t ms[N];
    obs_t q[N][$];
    int   checks = 0;
    int   errors = 0;

    function automatic int sat(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    function automatic void model(input mst_t s, input stim_t x, input int fl, input int rc,
                                  input int w, output obs_t e, output mst_t n);
        int need;
        bit dep;
        n = s;
        e = '{0, 0, 0, 0, 0, s.bc, s.tc, s.hc, 0};
        e.chk = !s.known ? 0 : (x.rst ? 1 : 2);
        case (x.typ)
            1:       need = 2;
            2:       need = 1;
            3, 4, 5: need = 3;
            default: need = 0;
        endcase
        dep = x.br && ((need & x.fwe) != 0);
        if (x.st) begin
            e.sF = 1; e.sD = 1; e.fE = 1;
        end else if (s.mode == 1) begin
            e.sF = 1; e.sD = 1; e.fE = 1;
            n.hc = sat(s.hc, w);
            n.left = s.left - 1;
            if (n.left == 0) n.mode = 0;
        end else if (s.mode == 2) begin
            e.fD = 1;
            n.left = s.left - 1;
            if (n.left == 0) n.mode = 0;
        end else if (dep) begin
            e.sF = 1; e.sD = 1; e.fE = 1;
            n.hc = sat(s.hc, w);
            if (fl > 1) begin n.mode = 1; n.left = fl - 1; end
        end else if (x.br) begin
            n.bc = sat(s.bc, w);
            if (x.tk) begin
                e.pr = 1; e.fD = 1;
                n.tc = sat(s.tc, w);
                if (rc > 1) begin n.mode = 2; n.left = rc - 1; end
            end
        end
        if (x.rst) n = '{0, 0, 0, 0, 0, 1'b1};
    endfunction

    task automatic apply(input stim_t x);
        obs_t e;
        mst_t n;
        @(posedge clk);
        #1;
        reset = x.rst;
        if0.branchD = x.br; if0.branchTypeD = 3'(x.typ); if0.takenD = x.tk;
        if0.flagWE = 2'(x.fwe); if0.stall_in = x.st;
        if1.branchD = x.br; if1.branchTypeD = 3'(x.typ); if1.takenD = x.tk;
        if1.flagWE = 2'(x.fwe); if1.stall_in = x.st;
        if2.branchD = x.br; if2.branchTypeD = 3'(x.typ); if2.takenD = x.tk;
        if2.flagWE = 2'(x.fwe); if2.stall_in = x.st;
        for (int i = 0; i < N; i++) begin
            model(ms[i], x, fl_p[i], rc_p[i], w_p[i], e, n);
            q[i].push_back(e);
            ms[i] = n;
        end
    endtask

    task automatic d(input bit rst, input bit br, input int typ, input bit tk,
                     input int fwe, input bit st);
        stim_t x;
        x = '{rst, br, typ, tk, fwe, st};
        apply(x);
    endtask

    function automatic obs_t get(input int i);
        obs_t a;
        case (i)
            0: a = '{if0.stallF, if0.stallD, if0.flushD, if0.flushE, if0.pcRedirect,
                     int'(if0.branch_cnt), int'(if0.taken_cnt), int'(if0.hazard_cnt), 2};
            1: a = '{if1.stallF, if1.stallD, if1.flushD, if1.flushE, if1.pcRedirect,
                     int'(if1.branch_cnt), int'(if1.taken_cnt), int'(if1.hazard_cnt), 2};
            default:
               a = '{if2.stallF, if2.stallD, if2.flushD, if2.flushE, if2.pcRedirect,
                     int'(if2.branch_cnt), int'(if2.taken_cnt), int'(if2.hazard_cnt), 2};
        endcase
        return a;
    endfunction

    task automatic cmp(input int i, input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL inst%0d %s at %0t: got %0d want %0d", i, name, $time, got, want);
        end
    endtask

    // Monitor: pops one prediction per instance on every falling edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (q[i].size() > 0) begin
                    e = q[i].pop_front();
                    a = get(i);
                    if (e.chk >= 1) begin
                        cmp(i, "branch_cnt", a.bc, e.bc);
                        cmp(i, "taken_cnt", a.tc, e.tc);
                        cmp(i, "hazard_cnt", a.hc, e.hc);
                    end
                    if (e.chk == 2) begin
                        cmp(i, "stallF", int'(a.sF), int'(e.sF));
                        cmp(i, "stallD", int'(a.sD), int'(e.sD));
                        cmp(i, "flushD", int'(a.fD), int'(e.fD));
                        cmp(i, "flushE", int'(a.fE), int'(e.fE));
                        cmp(i, "pcRedirect", int'(a.pr), int'(e.pr));
                        cmp(i, "redirect_vs_stallF", int'(a.pr & a.sF), 0);
                        cmp(i, "flushD_vs_stallD", int'(a.fD & a.sD), 0);
                    end
                end
            end
        end
    end

    initial begin
        stim_t x;
        reset = 1'b1;
        if0.branchD = 0; if0.branchTypeD = 0; if0.takenD = 0; if0.flagWE = 0; if0.stall_in = 0;
        if1.branchD = 0; if1.branchTypeD = 0; if1.takenD = 0; if1.flagWE = 0; if1.stall_in = 0;
        if2.branchD = 0; if2.branchTypeD = 0; if2.takenD = 0; if2.flagWE = 0; if2.stall_in = 0;
        for (int i = 0; i < N; i++) ms[i] = '{0, 0, 0, 0, 0, 1'b0};

        d(1, 0, 0, 0, 0, 0);
        d(1, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // unconditional jump, flag writer irrelevant
        d(0, 1, 6, 1, 3, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // JE against an upper-flag writer, then re-evaluated not taken
        d(0, 1, 1, 1, 2, 0);
        d(0, 1, 1, 0, 0, 0);
        d(0, 1, 1, 0, 0, 0);
        d(0, 1, 1, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // JE with a lower-flag writer: no hazard
        d(0, 1, 1, 1, 1, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // JG hazard with takenD toggling while waiting
        d(0, 1, 5, 0, 1, 0);
        d(0, 1, 5, 1, 0, 0);
        d(0, 1, 5, 0, 0, 0);
        d(0, 1, 5, 1, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // taken JB with wrong-path branches during the redirect
        d(0, 1, 2, 1, 0, 0);
        d(0, 1, 2, 1, 0, 0);
        d(0, 1, 6, 1, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // stall_in against a taken JA, then stall in the middle of the redirect
        d(0, 1, 3, 1, 0, 1);
        d(0, 1, 3, 1, 0, 0);
        d(0, 1, 3, 1, 0, 1);
        d(0, 1, 3, 1, 0, 1);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // reset while waiting on flags
        d(0, 1, 4, 0, 3, 0);
        d(1, 1, 4, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);
        // enough taken jumps to saturate the narrow counters, then reset
        for (int k = 0; k < 20; k++) begin
            d(0, 1, 6, 1, 0, 0);
            d(0, 0, 0, 0, 0, 0);
            d(0, 0, 0, 0, 0, 0);
        end
        d(1, 0, 0, 0, 0, 0);
        d(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 4000; k++) begin
            x.rst = ($urandom_range(0, 149) == 0);
            x.br  = ($urandom_range(0, 99) < 60);
            x.typ = int'($urandom_range(0, 7));
            x.tk  = $urandom_range(0, 1) == 1;
            x.fwe = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
            x.st  = ($urandom_range(0, 7) == 0);
            apply(x);
        end

        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) cmp(i, "queue_drained", q[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
